// File: rtl/commit_lockstep_checker_pkg.sv
// Shared types for the lockstep retire-stream checker: commit record layout,
// FSM states and failure codes.
package commit_lockstep_checker_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [ILEN-1:0] instr_t;

    typedef struct packed {
        data_t      pc;
        instr_t     instr;
        logic       rd_we;
        logic [4:0] rd;
        data_t      wdata;
    } commit_rec_t;

    localparam int unsigned REC_W = $bits(commit_rec_t);

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_RUN  = 2'd1,
        CHK_FAIL = 2'd2
    } chk_state_e;

    typedef enum logic [2:0] {
        FAIL_NONE    = 3'd0,
        FAIL_PC      = 3'd1,
        FAIL_INSTR   = 3'd2,
        FAIL_WB      = 3'd3,
        FAIL_TIMEOUT = 3'd4,
        FAIL_OVF     = 3'd5
    } fail_code_e;

endpackage

// File: rtl/commit_lockstep_checker_if.sv
// Retire-stream bundle between the two cores and the checker; the reference
// core is throttled through ref_stall_o.
interface commit_lockstep_checker_if;
    import commit_lockstep_checker_pkg::*;

    logic        dut_valid_i;
    commit_rec_t dut_rec_i;
    logic        ref_valid_i;
    commit_rec_t ref_rec_i;
    logic        ref_stall_o;

    modport master (
        output dut_valid_i, dut_rec_i, ref_valid_i, ref_rec_i,
        input  ref_stall_o
    );

    modport slave (
        input  dut_valid_i, dut_rec_i, ref_valid_i, ref_rec_i,
        output ref_stall_o
    );

endinterface

// File: rtl/commit_lockstep_checker_fifo.sv
// Commit record FIFO: wrap-bit pointers, async reset, sync flush.
// A push while full is dropped unless the head pops in the same cycle.
module commit_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             head_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_full;
    logic         w_push;
    logic         w_pop;

    assign empty_c = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign count_c = r_wptr - r_rptr;
    assign head_c  = r_mem[r_rptr[AW-1:0]];
    assign w_pop   = pop_i && !empty_c;
    assign w_push  = push_i && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/commit_lockstep_checker.sv
// Lockstep comparator: buffers DUT and reference retire streams, pops matching
// heads pairwise, and latches the first divergence, timeout or overflow.
module commit_lockstep_checker
    import commit_lockstep_checker_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned STALL_LVL   = 6,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned CHECK_WDATA = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable_i,
    commit_lockstep_checker_if.slave   bus,
    output logic [CNT_W-1:0]           match_cnt_o,
    output logic                       fail_o,
    output logic [2:0]                 fail_code_o,
    output logic [XLEN-1:0]            fail_pc_o,
    output commit_rec_t                fail_dut_o,
    output commit_rec_t                fail_ref_o
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned TW     = $clog2(TIMEOUT + 1);
    localparam bit          CMP_WB = (CHECK_WDATA != 0);

    chk_state_e       r_state;
    logic [CNT_W-1:0] r_match_cnt;
    logic [TW-1:0]    r_to_cnt;
    logic             r_ref_stall;
    logic             r_fail;
    fail_code_e       r_fail_code;
    logic [XLEN-1:0]  r_fail_pc;
    commit_rec_t      r_fail_dut;
    commit_rec_t      r_fail_ref;

    commit_rec_t w_dut_head;
    commit_rec_t w_ref_head;
    logic        w_dut_empty;
    logic        w_ref_empty;
    logic [CW-1:0] w_dut_cnt;
    logic [CW-1:0] w_ref_cnt;
    logic [CW-1:0] w_ref_cnt_nxt;
    logic        w_run;
    logic        w_flush;
    logic        w_dut_push;
    logic        w_ref_push;
    logic        w_dut_full;
    logic        w_ref_full;
    logic        w_both;
    logic        w_one_side;
    logic        w_match;
    logic        w_wb_ne;
    logic        w_dut_ovf;
    logic        w_ref_ovf;
    logic        w_ref_push_acc;
    logic        w_to_hit;
    fail_code_e  w_cmp_code;
    fail_code_e  w_fail_code;

    assign w_run      = (r_state == CHK_RUN);
    assign w_flush    = (r_state == CHK_IDLE) || !enable_i;
    assign w_dut_push = w_run && bus.dut_valid_i;
    assign w_ref_push = w_run && bus.ref_valid_i;

    commit_fifo #(.DEPTH(FIFO_DEPTH), .W(REC_W)) u_dut_fifo (
        .clk(clk), .rst_n(rst_n), .flush_i(w_flush), .push_i(w_dut_push), .pop_i(w_match),
        .din_i(bus.dut_rec_i), .head_c(w_dut_head), .empty_c(w_dut_empty), .count_c(w_dut_cnt)
    );

    commit_fifo #(.DEPTH(FIFO_DEPTH), .W(REC_W)) u_ref_fifo (
        .clk(clk), .rst_n(rst_n), .flush_i(w_flush), .push_i(w_ref_push), .pop_i(w_match),
        .din_i(bus.ref_rec_i), .head_c(w_ref_head), .empty_c(w_ref_empty), .count_c(w_ref_cnt)
    );

    assign w_dut_full = (w_dut_cnt == CW'(FIFO_DEPTH));
    assign w_ref_full = (w_ref_cnt == CW'(FIFO_DEPTH));
    assign w_both     = !w_dut_empty && !w_ref_empty;
    assign w_one_side = (w_dut_empty != w_ref_empty);
    assign w_wb_ne    = CMP_WB && ((w_dut_head.rd_we != w_ref_head.rd_we) ||
                        (w_dut_head.rd_we && ((w_dut_head.rd != w_ref_head.rd) ||
                                              (w_dut_head.wdata != w_ref_head.wdata))));
    assign w_match    = w_run && w_both && (w_cmp_code == FAIL_NONE);
    assign w_dut_ovf  = w_dut_push && w_dut_full && !w_match;
    assign w_ref_ovf  = w_ref_push && w_ref_full && !w_match;
    assign w_to_hit   = w_run && w_one_side && (r_to_cnt == TW'(TIMEOUT - 1));

    // Occupancy after this edge drives the registered stall.
    assign w_ref_push_acc = w_ref_push && (!w_ref_full || w_match);
    assign w_ref_cnt_nxt  = w_ref_cnt + CW'(w_ref_push_acc) - CW'(w_match);

    // Head comparison in priority order, then event priority: overflow > mismatch > timeout.
    always_comb begin
        w_cmp_code = FAIL_NONE;
        if (w_both) begin
            if (w_dut_head.pc != w_ref_head.pc)          w_cmp_code = FAIL_PC;
            else if (w_dut_head.instr != w_ref_head.instr) w_cmp_code = FAIL_INSTR;
            else if (w_wb_ne)                             w_cmp_code = FAIL_WB;
        end
        w_fail_code = FAIL_NONE;
        if (w_run) begin
            if (w_dut_ovf || w_ref_ovf)       w_fail_code = FAIL_OVF;
            else if (w_cmp_code != FAIL_NONE) w_fail_code = w_cmp_code;
            else if (w_to_hit)                w_fail_code = FAIL_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CHK_IDLE;
            r_match_cnt <= '0;
            r_to_cnt    <= '0;
            r_ref_stall <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= FAIL_NONE;
            r_fail_pc   <= '0;
            r_fail_dut  <= '0;
            r_fail_ref  <= '0;
        end else begin
            case (r_state)
                CHK_IDLE: begin
                    r_ref_stall <= 1'b0;
                    r_to_cnt    <= '0;
                    if (enable_i) r_state <= CHK_RUN;
                end
                CHK_RUN: begin
                    if (!enable_i) begin
                        r_state     <= CHK_IDLE;
                        r_ref_stall <= 1'b0;
                        r_to_cnt    <= '0;
                    end else begin
                        r_ref_stall <= (32'(w_ref_cnt_nxt) >= STALL_LVL);
                        if (w_match && (r_match_cnt != {CNT_W{1'b1}}))
                            r_match_cnt <= r_match_cnt + CNT_W'(1);
                        if (w_match || !w_one_side) r_to_cnt <= '0;
                        else                        r_to_cnt <= r_to_cnt + TW'(1);
                        if (w_fail_code != FAIL_NONE) begin
                            r_state     <= CHK_FAIL;
                            r_ref_stall <= 1'b1;
                            r_fail      <= 1'b1;
                            r_fail_code <= w_fail_code;
                            r_fail_pc   <= w_dut_empty ? w_ref_head.pc : w_dut_head.pc;
                            r_fail_dut  <= w_dut_empty ? '0 : w_dut_head;
                            r_fail_ref  <= w_ref_empty ? '0 : w_ref_head;
                        end
                    end
                end
                CHK_FAIL: begin
                    // Frozen until disabled; match count survives the exit.
                    if (!enable_i) begin
                        r_state     <= CHK_IDLE;
                        r_ref_stall <= 1'b0;
                        r_to_cnt    <= '0;
                        r_fail      <= 1'b0;
                        r_fail_code <= FAIL_NONE;
                        r_fail_pc   <= '0;
                        r_fail_dut  <= '0;
                        r_fail_ref  <= '0;
                    end
                end
                default: r_state <= CHK_IDLE;
            endcase
        end
    end

    assign bus.ref_stall_o = r_ref_stall;
    assign match_cnt_o     = r_match_cnt;
    assign fail_o          = r_fail;
    assign fail_code_o     = r_fail_code;
    assign fail_pc_o       = r_fail_pc;
    assign fail_dut_o      = r_fail_dut;
    assign fail_ref_o      = r_fail_ref;

endmodule

// File: tb/tb_commit_lockstep_checker.sv
// Directed bench for commit_lockstep_checker: a compare-priority vector table
// plus hand-written stream, latency, timeout, overflow and reset sequences.
module tb_commit_lockstep_checker;
    import commit_lockstep_checker_pkg::*;

    logic clk;
    logic rst_n;
    logic enable;
    int   n_checks;
    int   n_errors;

    commit_lockstep_checker_if if_a ();
    commit_lockstep_checker_if if_b ();

    logic [31:0]   a_match, b_match;
    logic          a_fail, b_fail;
    logic [2:0]    a_code, b_code;
    logic [31:0]   a_pc, b_pc;
    commit_rec_t   a_fdut, a_fref, b_fdut, b_fref;

    commit_lockstep_checker #(.FIFO_DEPTH(8), .STALL_LVL(6), .TIMEOUT(16), .CHECK_WDATA(1), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .bus(if_a),
        .match_cnt_o(a_match), .fail_o(a_fail), .fail_code_o(a_code),
        .fail_pc_o(a_pc), .fail_dut_o(a_fdut), .fail_ref_o(a_fref)
    );

    commit_lockstep_checker #(.FIFO_DEPTH(8), .STALL_LVL(6), .TIMEOUT(16), .CHECK_WDATA(0), .CNT_W(32)) u_nowb (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .bus(if_b),
        .match_cnt_o(b_match), .fail_o(b_fail), .fail_code_o(b_code),
        .fail_pc_o(b_pc), .fail_dut_o(b_fdut), .fail_ref_o(b_fref)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        commit_rec_t d;
        commit_rec_t r;
        logic [2:0]  code_wb;
        logic [2:0]  code_nowb;
    } vec_t;

    vec_t vt [9];

    function automatic commit_rec_t mk_rec(input int n);
        commit_rec_t r;
        r.pc    = 32'(4 * n);
        r.instr = 32'h0000_0013 | (32'(n) << 20);
        r.rd_we = n[0];
        r.rd    = 5'(n);
        r.wdata = 32'(n * 7 + 1);
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input commit_rec_t d, input logic rv, input commit_rec_t r);
        if_a.dut_valid_i = dv; if_a.dut_rec_i = d; if_a.ref_valid_i = rv; if_a.ref_rec_i = r;
        if_b.dut_valid_i = dv; if_b.dut_rec_i = d; if_b.ref_valid_i = rv; if_b.ref_rec_i = r;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0);
    endtask

    // Reset, then arm: checker is in RUN after this returns.
    task automatic do_reset();
        idle();
        enable = 1'b0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
    endtask

    initial begin
        commit_rec_t b;
        commit_rec_t d;
        commit_rec_t r;
        logic        stall_seen;

        n_checks = 0;
        n_errors = 0;
        enable   = 1'b0;
        rst_n    = 1'b0;
        idle();
        #2;
        check("reset_match", 128'(a_match), 128'(0));
        check("reset_fail", 128'(a_fail), 128'(0));
        check("reset_stall", 128'(if_a.ref_stall_o), 128'(0));

        // Compare-priority table
        b = mk_rec(5);
        for (int i = 0; i < 9; i++) begin
            vt[i].d = b; vt[i].r = b; vt[i].d.rd_we = 1'b1; vt[i].r.rd_we = 1'b1;
        end
        vt[0].code_wb = 3'd0; vt[0].code_nowb = 3'd0;
        vt[1].d.pc = 32'h0000_0100; vt[1].code_wb = 3'd1; vt[1].code_nowb = 3'd1;
        vt[2].d.instr = 32'h0000_0033; vt[2].code_wb = 3'd2; vt[2].code_nowb = 3'd2;
        vt[3].d.pc = 32'h0000_0100; vt[3].d.instr = 32'h0000_0033; vt[3].code_wb = 3'd1; vt[3].code_nowb = 3'd1;
        vt[4].d.rd_we = 1'b0; vt[4].code_wb = 3'd3; vt[4].code_nowb = 3'd0;
        vt[5].d.rd = 5'd9; vt[5].code_wb = 3'd3; vt[5].code_nowb = 3'd0;
        vt[6].d.rd_we = 1'b0; vt[6].r.rd_we = 1'b0; vt[6].d.wdata = 32'hdead; vt[6].code_wb = 3'd0; vt[6].code_nowb = 3'd0;
        vt[7].d.rd_we = 1'b0; vt[7].r.rd_we = 1'b0; vt[7].d.rd = 5'd1; vt[7].code_wb = 3'd0; vt[7].code_nowb = 3'd0;
        vt[8].d.instr = 32'h0000_0033; vt[8].d.wdata = 32'hbeef; vt[8].code_wb = 3'd2; vt[8].code_nowb = 3'd2;

        for (int i = 0; i < 9; i++) begin
            do_reset();
            drive(1'b1, vt[i].d, 1'b1, vt[i].r);
            tick();
            idle();
            tick();
            check($sformatf("vec%0d_code_wb", i), 128'(a_code), 128'(vt[i].code_wb));
            check($sformatf("vec%0d_code_nowb", i), 128'(b_code), 128'(vt[i].code_nowb));
            check($sformatf("vec%0d_match", i), 128'(a_match), 128'((vt[i].code_wb == 3'd0) ? 1 : 0));
        end

        // Identical streams, same cycle
        do_reset();
        stall_seen = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            drive(1'b1, mk_rec(n), 1'b1, mk_rec(n));
            tick();
            if (if_a.ref_stall_o) stall_seen = 1'b1;
        end
        idle();
        tick();
        tick();
        check("same_match", 128'(a_match), 128'(100));
        check("same_fail", 128'(a_fail), 128'(0));
        check("same_stall", 128'(stall_seen), 128'(0));

        // DUT leads reference by 5 cycles
        do_reset();
        stall_seen = 1'b0;
        for (int c = 0; c < 105; c++) begin
            drive(c < 100, mk_rec(c + 1), c >= 5, mk_rec(c - 4));
            tick();
            if (if_a.ref_stall_o) stall_seen = 1'b1;
        end
        idle();
        tick();
        tick();
        check("lead_match", 128'(a_match), 128'(100));
        check("lead_fail", 128'(a_fail), 128'(0));
        check("lead_stall", 128'(stall_seen), 128'(0));

        // pc divergence at record 37
        do_reset();
        for (int n = 1; n <= 37; n++) begin
            d = mk_rec(n);
            if (n == 37) d.pc = 32'h0000_0098;
            drive(1'b1, d, 1'b1, mk_rec(n));
            tick();
        end
        idle();
        check("pc_fail_latency", 128'(a_fail), 128'(0));
        tick();
        check("pc_fail", 128'(a_fail), 128'(1));
        check("pc_code", 128'(a_code), 128'(1));
        check("pc_fail_pc", 128'(a_pc), 128'(32'h98));
        check("pc_match", 128'(a_match), 128'(36));
        check("pc_cap_dut", 128'(a_fdut), 128'(d));
        check("pc_cap_ref", 128'(a_fref), 128'(mk_rec(37)));
        check("pc_fail_stall", 128'(if_a.ref_stall_o), 128'(1));
        enable = 1'b0;
        tick();
        check("disable_fail", 128'(a_fail), 128'(0));
        check("disable_code", 128'(a_code), 128'(0));
        check("disable_match_held", 128'(a_match), 128'(36));

        // Writeback data mismatch at rd=x10
        do_reset();
        for (int n = 1; n <= 4; n++) begin
            d = mk_rec(n);
            r = mk_rec(n);
            if (n == 3) begin
                d.rd_we = 1'b1; d.rd = 5'd10; d.wdata = 32'h5;
                r.rd_we = 1'b1; r.rd = 5'd10; r.wdata = 32'h6;
            end
            drive(1'b1, d, 1'b1, r);
            tick();
        end
        idle();
        tick();
        tick();
        check("wb_code", 128'(a_code), 128'(3));
        check("wb_match", 128'(a_match), 128'(2));
        check("nowb_fail", 128'(b_fail), 128'(0));
        check("nowb_match", 128'(b_match), 128'(4));

        // Reference-only pushes: stall then timeout
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            if (k < 8) drive(1'b0, '0, 1'b1, mk_rec(k + 1));
            else       idle();
            tick();
            if (k < 8)   check($sformatf("to_stall_k%0d", k), 128'(if_a.ref_stall_o), 128'((k >= 5) ? 1 : 0));
            if (k == 15) check("to_fail_early", 128'(a_fail), 128'(0));
        end
        check("to_fail", 128'(a_fail), 128'(1));
        check("to_code", 128'(a_code), 128'(4));
        check("to_pc", 128'(a_pc), 128'(32'h4));
        check("to_cap_dut", 128'(a_fdut), 128'(0));
        check("to_cap_ref", 128'(a_fref), 128'(mk_rec(1)));

        // Overflow on ninth reference push, then async reset mid-cycle
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            drive(1'b0, '0, 1'b1, mk_rec(k + 1));
            tick();
            if (k == 7) check("ovf_fail_early", 128'(a_fail), 128'(0));
        end
        check("ovf_fail", 128'(a_fail), 128'(1));
        check("ovf_code", 128'(a_code), 128'(5));
        check("ovf_pc", 128'(a_pc), 128'(32'h4));
        check("ovf_stall", 128'(if_a.ref_stall_o), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fail", 128'(a_fail), 128'(0));
        check("arst_code", 128'(a_code), 128'(0));
        check("arst_pc", 128'(a_pc), 128'(0));
        check("arst_match", 128'(a_match), 128'(0));
        check("arst_stall", 128'(if_a.ref_stall_o), 128'(0));
        check("arst_cap_dut", 128'(a_fdut), 128'(0));
        check("arst_cap_ref", 128'(a_fref), 128'(0));
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
